uart_cmd_responder: RTL
=======================

# uart_cmd_responder

Byte-level command responder on the host side of the UART line block. Consumes received bytes (`rx_data`/`rx_valid`), parses fixed 5-byte command frames, performs one register read or write on a simple internal register bus, and returns a fixed 4-byte response frame through the UART transmit handshake (`tx_data`/`tx_start`/`tx_busy`). It is the protocol responder for a PC-side initiator.

## Interface
- `ADDR_W`, 8: register bus address width; frame address byte is zero-extended or truncated to this width.
- `TIMEOUT`, 5300: inter-byte timeout in `clk` cycles, about 10 byte times at 921600 baud / 50 MHz.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte, valid when `rx_valid` rises.
- `rx_valid`  in  1  new-byte flag from UART; level may persist for several cycles; only its rising edge counts.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_data`  out  8  byte to transmit.
- `tx_start`  out  1  transmit request (level, see Timing).
- `reg_addr`  out  ADDR_W  register address.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_re`.
- `busy`  out  1  high from first non-sync byte accepted until response fully sent.
- `err_cnt`  out  8  saturating count of rejected frames.

## Operation
- Command frame: `0xA5`, CMD, ADDR, DATA, CSUM; CSUM = CMD^ADDR^DATA.
- CMD `0x01` = write DATA to ADDR; CMD `0x02` = read ADDR (DATA ignored but included in CSUM).
- Response frame: `0x5A`, STATUS, RDATA, STATUS^RDATA.
- STATUS `0x00` OK; `0xE1` checksum error; `0xE2` unknown CMD. Checksum is checked before CMD.
- On a write OK, RDATA echoes the written DATA. On a read OK, RDATA is the captured `reg_rdata`. On an error, RDATA is `0x00`, no bus access occurs, and `err_cnt` increments (saturating at 255).
- FSM states:
  - HUNT: discard bytes other than `0xA5`.
  - CMD, ADDR, DATA, CSUM: capture one byte each.
  - EXEC: check the frame and issue the strobe.
  - RDWAIT: capture `reg_rdata`; read only.
  - RESP: send 4 bytes, then return to HUNT.
- `0xA5` received in CMD/ADDR/DATA/CSUM is treated as a field value, not a resync.
- Bytes arriving in EXEC/RDWAIT/RESP are dropped.
- Reset values: all outputs 0; FSM in HUNT; `err_cnt` 0.

## Timing
- Rising edge of `rx_valid` is detected with one register; the FSM advances on the cycle after the edge.
- EXEC is entered 1 cycle after the CSUM edge is detected.
- `reg_we`/`reg_re` are high for exactly the EXEC cycle. `reg_addr` and `reg_wdata` are stable from EXEC until the next frame's EXEC.
- Read: RDWAIT samples `reg_rdata` one cycle after `reg_re`.
- RESP handshake, per byte:
  - Drive `tx_data` and raise `tx_start`.
  - Hold both until `tx_busy` is seen high, then drop `tx_start` the next cycle.
  - Wait for `tx_busy` low before the next byte.
  - `tx_start` must never be high while `tx_busy` is low after that byte has started; this prevents duplicate sends.
- First `tx_start` rises the cycle after EXEC (write/error) or after RDWAIT (read).
- `busy` drops in the cycle in which the FSM returns to HUNT.
- Asynchronous reset mid-frame or mid-response aborts immediately. The partial response is not completed.

## Configuration
- `UART_RESP_TIMEOUT_EN` defined:
  - A counter restarts on every accepted byte in CMD..CSUM.
  - When it reaches `TIMEOUT`, the FSM returns to HUNT silently. There is no response and `err_cnt` is unchanged.
  - The counter is held at 0 in HUNT/EXEC/RDWAIT/RESP.
- Not defined: no counter is built, and a partial frame waits indefinitely.

## Structure
- Shared package `uart_resp_pkg`:
  - sync bytes `0xA5`/`0x5A`
  - CMD codes `0x01`/`0x02`
  - STATUS codes `0x00`/`0xE1`/`0xE2`
  - FSM state encoding
- Sub-module `uart_resp_tx_seq`: takes a 4-byte response and a start pulse, runs the `tx_start`/`tx_busy` handshake per byte, and returns a done pulse.

## Test plan
- Write: `A5 01 10 3C 2D` → one-cycle `reg_we` with `reg_addr`=0x10 and `reg_wdata`=0x3C; response `5A 00 3C 3C`; `err_cnt`=0.
- Read: `A5 02 10 00 12` with `reg_rdata`=0x77 → one-cycle `reg_re` with `reg_addr`=0x10; response `5A 00 77 77`.
- Bad checksum: `A5 01 10 3C 00` → no `reg_we`; response `5A E1 00 E1`; `err_cnt`=1. Then bad CMD `A5 07 00 00 07` → response `5A E2 00 E2`; `err_cnt`=2.
- Junk and handshake: `00 FF A5 02 10 00 12` with `rx_valid` held high 3 cycles per byte, and a UART model delaying `tx_busy` rise by 2 cycles → exactly one read and exactly 4 transmitted bytes.
- Timeout (`UART_RESP_TIMEOUT_EN`): send `A5 01`, idle for `TIMEOUT`+1 cycles, then send a full read frame → read response only, no write, `err_cnt` unchanged.
- Reset asserted during the second response byte → all outputs 0 within the same cycle. A subsequent write frame works normally.

Source files
------------

// File: rtl/uart_resp_pkg.sv
// Shared constants for the UART command responder: frame sync bytes,
// command and status codes, FSM state encodings and the response frame
// layout. Used by uart_cmd_responder and uart_resp_tx_seq.
package uart_resp_pkg;

   // Frame sync bytes
   localparam logic [7:0] SYNC_CMD  = 8'hA5;
   localparam logic [7:0] SYNC_RESP = 8'h5A;

   // Command codes
   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;

   // Response status codes
   localparam logic [7:0] STS_OK       = 8'h00;
   localparam logic [7:0] STS_CSUM_ERR = 8'hE1;
   localparam logic [7:0] STS_CMD_ERR  = 8'hE2;

   // Frame parser states
   localparam logic [2:0] ST_HUNT   = 3'd0;
   localparam logic [2:0] ST_CMD    = 3'd1;
   localparam logic [2:0] ST_ADDR   = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_CSUM   = 3'd4;
   localparam logic [2:0] ST_EXEC   = 3'd5;
   localparam logic [2:0] ST_RDWAIT = 3'd6;
   localparam logic [2:0] ST_RESP   = 3'd7;

   // Transmit sequencer phases
   localparam logic [1:0] TX_IDLE = 2'd0;
   localparam logic [1:0] TX_REQ  = 2'd1;
   localparam logic [1:0] TX_WAIT = 2'd2;

   // Response frame, first byte on the wire is 'sync'
   typedef struct packed {
      logic [7:0] sync;
      logic [7:0] status;
      logic [7:0] rdata;
      logic [7:0] chk;
   } resp_t;

   // Build a response frame; the trailer is STATUS^RDATA.
   function automatic resp_t make_resp(input logic [7:0] status,
                                       input logic [7:0] rdata);
      resp_t r;
      r.sync   = SYNC_RESP;
      r.status = status;
      r.rdata  = rdata;
      r.chk    = status ^ rdata;
      return r;
   endfunction

   // Select byte i (0 = first on the wire) of a response frame.
   function automatic logic [7:0] resp_byte(input resp_t r,
                                            input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = r.sync;
         2'd1:    b = r.status;
         2'd2:    b = r.rdata;
         default: b = r.chk;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_resp_tx_seq.sv
// Response transmit sequencer: on a start pulse, latches a 4-byte response
// and sends it byte by byte over the tx_start/tx_busy handshake. tx_start is
// held with tx_data until tx_busy is seen high, dropped the next cycle, and
// the next byte is only requested once tx_busy has returned low. 'done' is
// high in the cycle the last byte's tx_busy is seen low.
module uart_resp_tx_seq
   import uart_resp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  resp_t      resp,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       done
);

   logic [1:0] phase;
   logic [1:0] idx;
   logic [1:0] idx_nxt;
   resp_t      resp_q;

   assign idx_nxt = idx + 2'd1;

   // Hold the response frame for the bytes after the first.
   // NOTE: resp_q is deliberately left without a reset; it is always loaded on
   // start before any of its bytes are read, so a reset would only add muxing.
   always_ff @(posedge clk) begin
      if (start && phase == TX_IDLE) begin
         resp_q <= resp;
      end
   end

   // Per-byte request/acknowledge handshake with the UART transmitter.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase    <= TX_IDLE;
         idx      <= 2'd0;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
      end else begin
         case (phase)
            TX_IDLE: begin
               if (start) begin
                  tx_data  <= resp.sync;
                  tx_start <= 1'b1;
                  idx      <= 2'd0;
                  phase    <= TX_REQ;
               end
            end
            TX_REQ: begin
               if (tx_busy) begin
                  tx_start <= 1'b0;
                  phase    <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               if (!tx_busy) begin
                  if (idx == 2'd3) begin
                     phase <= TX_IDLE;
                  end else begin
                     idx      <= idx_nxt;
                     tx_data  <= resp_byte(resp_q, idx_nxt);
                     tx_start <= 1'b1;
                     phase    <= TX_REQ;
                  end
               end
            end
            default: phase <= TX_IDLE;
         endcase
      end
   end

   assign done = (phase == TX_WAIT) && !tx_busy && (idx == 2'd3);

endmodule

// File: rtl/uart_cmd_responder.sv
// UART command responder. Parses 5-byte command frames
// (A5, CMD, ADDR, DATA, CMD^ADDR^DATA) from the receive byte stream, performs
// one register write or read, and answers with a 4-byte response frame
// (5A, STATUS, RDATA, STATUS^RDATA) through uart_resp_tx_seq.
// Optional feature: define UART_RESP_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT idle cycles; without it a partial frame waits indefinitely.
module uart_cmd_responder
   import uart_resp_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 5300
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              tx_busy,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   logic [2:0] state;
   logic       rx_valid_q;
   logic       rx_edge;
   logic [7:0] f_cmd;
   logic [7:0] f_addr;
   logic [7:0] f_data;
   logic [7:0] f_csum;
   logic       csum_ok;
   logic       cmd_ok;
   logic [7:0] status;
   logic [7:0] resp_rdata;
   logic       write_ok;
   logic       read_ok;
   logic       in_frame;
   logic       timeout_hit;
   logic       tx_go;
   logic       tx_done;
   resp_t      resp;

   // A byte counts only on the rising edge of rx_valid.
   assign rx_edge  = rx_valid && !rx_valid_q;
   assign in_frame = (state == ST_CMD) || (state == ST_ADDR) ||
                     (state == ST_DATA) || (state == ST_CSUM);

   // Frame checks; fields are frozen from EXEC until the next frame starts.
   assign csum_ok  = ((f_cmd ^ f_addr ^ f_data) == f_csum);
   assign cmd_ok   = (f_cmd == CMD_WRITE) || (f_cmd == CMD_READ);
   assign write_ok = (status == STS_OK) && (f_cmd == CMD_WRITE);
   assign read_ok  = (status == STS_OK) && (f_cmd == CMD_READ);

   // Status priority: checksum error before unknown command.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      status = STS_OK;
      if (!csum_ok) begin
         status = STS_CSUM_ERR;
      end else if (!cmd_ok) begin
         status = STS_CMD_ERR;
      end
   end

   // Response data: captured read data, echoed write data, or zero on error.
   always_comb begin
      resp_rdata = 8'h00;
      if (state == ST_RDWAIT) begin
         resp_rdata = reg_rdata;
      end else if (status == STS_OK) begin
         resp_rdata = f_data;
      end
   end

   assign resp = make_resp(status, resp_rdata);

   // Launch the response straight out of EXEC, or out of RDWAIT for reads.
   assign tx_go = ((state == ST_EXEC) && !read_ok) || (state == ST_RDWAIT);

   // Bus strobes last exactly the EXEC cycle.
   assign reg_we = (state == ST_EXEC) && write_ok;
   assign reg_re = (state == ST_EXEC) && read_ok;

   // Busy once a frame body is underway, until back in HUNT.
   assign busy = (state != ST_HUNT) && (state != ST_CMD);

`ifdef UART_RESP_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] idle_cnt;

   // Inter-byte idle counter, restarted by each frame byte, parked outside CMD..CSUM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt <= '0;
      end else if (!in_frame || rx_edge || timeout_hit) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // A byte arriving in the expiry cycle still counts.
   assign timeout_hit = in_frame && !rx_edge && (idle_cnt == CNT_W'(TIMEOUT));
`else
   // TIMEOUT has no effect in this build; a partial frame waits indefinitely.
   assign timeout_hit = (TIMEOUT < 0);
`endif

   // Frame parser, register access and response control.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_HUNT;
         rx_valid_q <= 1'b0;
         f_cmd      <= 8'h00;
         f_addr     <= 8'h00;
         f_data     <= 8'h00;
         f_csum     <= 8'h00;
         reg_addr   <= '0;
         reg_wdata  <= 8'h00;
         err_cnt    <= 8'h00;
      end else begin
         rx_valid_q <= rx_valid;
         if (timeout_hit) begin
            state <= ST_HUNT;
         end else begin
            case (state)
               ST_HUNT: begin
                  if (rx_edge && rx_data == SYNC_CMD) begin
                     state <= ST_CMD;
                  end
               end
               ST_CMD: begin
                  if (rx_edge) begin
                     f_cmd <= rx_data;
                     state <= ST_ADDR;
                  end
               end
               ST_ADDR: begin
                  if (rx_edge) begin
                     f_addr <= rx_data;
                     state  <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (rx_edge) begin
                     f_data <= rx_data;
                     state  <= ST_CSUM;
                  end
               end
               ST_CSUM: begin
                  if (rx_edge) begin
                     f_csum    <= rx_data;
                     reg_addr  <= ADDR_W'(f_addr);
                     reg_wdata <= f_data;
                     state     <= ST_EXEC;
                  end
               end
               ST_EXEC: begin
                  if (status != STS_OK && err_cnt != 8'hFF) begin
                     err_cnt <= err_cnt + 8'd1;
                  end
                  state <= read_ok ? ST_RDWAIT : ST_RESP;
               end
               ST_RDWAIT: begin
                  state <= ST_RESP;
               end
               ST_RESP: begin
                  if (tx_done) begin
                     state <= ST_HUNT;
                  end
               end
               default: state <= ST_HUNT;
            endcase
         end
      end
   end

   uart_resp_tx_seq u_tx_seq (
      .clk      (clk),
      .reset    (reset),
      .start    (tx_go),
      .resp     (resp),
      .tx_busy  (tx_busy),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .done     (tx_done)
   );

endmodule
